// File: rtl/fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_ctrl
// Brief    : Write-side controller of the async FIFO (wr_clk domain).
//            Optional sticky overflow port: define FIFO_WR_OVERFLOW_EN.
// Revision : 1.0  initial release
// ============================================================================
module fifo_wr_ctrl #(
    parameter int ADDR_W    = 3,
    parameter int AF_THRESH = 6
) (
    input  logic              wr_clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   b_rd_ptr_sync,
    output logic [ADDR_W:0]   b_wr_ptr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              mem_we,
    output logic              full,
    output logic              almost_full,
`ifdef FIFO_WR_OVERFLOW_EN
    output logic              overflow,
`endif
    output logic [ADDR_W:0]   wr_level
);

    localparam logic [ADDR_W:0] c_AF_THRESH = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] c_ONE       = (ADDR_W+1)'(1);

    logic              w_accept;
    logic [ADDR_W:0]   w_wr_ptr_next;
    logic [ADDR_W:0]   w_lvl_next;
    logic              w_full_next;
    logic              w_af_next;

    assign w_accept = wr_en & ~full;
    assign mem_we   = w_accept;
    assign wr_addr  = b_wr_ptr[ADDR_W-1:0];

    // Pointer and level wrap naturally modulo 2^(ADDR_W+1).
    assign w_wr_ptr_next = w_accept ? (b_wr_ptr + c_ONE) : b_wr_ptr;
    assign w_lvl_next    = w_wr_ptr_next - b_rd_ptr_sync;
    assign w_full_next   = (w_wr_ptr_next[ADDR_W] != b_rd_ptr_sync[ADDR_W]) &&
                           (w_wr_ptr_next[ADDR_W-1:0] == b_rd_ptr_sync[ADDR_W-1:0]);
    assign w_af_next     = (w_lvl_next >= c_AF_THRESH);

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            b_wr_ptr    <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
        end else begin
            b_wr_ptr    <= w_wr_ptr_next;
            full        <= w_full_next;
            almost_full <= w_af_next;
            wr_level    <= w_lvl_next;
        end
    end

`ifdef FIFO_WR_OVERFLOW_EN
    // Sticky: any write attempted while full is remembered until reset.
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
- Write-side controller of the asynchronous FIFO. Lives in the wr_clk domain.
- Consumes the read pointer after it has been synchronized into the write domain.
- Owns the binary write pointer and generates the RAM write strobe and address.
- Produces full, almost-full and occupancy-level status for the writer.

Parameters:
- ADDR_W, 3, RAM address width; FIFO depth = 2^ADDR_W.
- AF_THRESH, 6, almost_full asserts when level >= AF_THRESH. Legal range 1..2^ADDR_W.

Ports:
- wr_clk  input  1  write-domain clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  write request from the producer.
- b_rd_ptr_sync  input  ADDR_W+1  read pointer, binary, already synchronized into wr_clk. MSB is the wrap bit.
- b_wr_ptr  output  ADDR_W+1  binary write pointer, registered. Drives the write-to-read pointer synchronizer.
- wr_addr  output  ADDR_W  RAM write address; equals b_wr_ptr[ADDR_W-1:0].
- mem_we  output  1  RAM write strobe; combinational, equals wr_en & ~full.
- full  output  1  registered full flag.
- almost_full  output  1  registered almost-full flag.
- wr_level  output  ADDR_W+1  registered occupancy as seen from the write domain, range 0..2^ADDR_W.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - b_wr_ptr=0, full=0, almost_full=0, wr_level=0; overflow=0 when that port is compiled in.
  - mem_we is therefore 0 until wr_en is asserted.
- Accept rule:
  - A write is accepted in a cycle where wr_en=1 and full=0.
  - mem_we=1 in that same cycle, and the RAM captures the data at wr_addr on that edge.
  - wr_en while full=1 is dropped: no strobe, no pointer change.
- Pointer:
  - wr_ptr_next = b_wr_ptr + 1 on accept, otherwise b_wr_ptr.
  - Arithmetic is modulo 2^(ADDR_W+1); e.g. ADDR_W=3 wraps 15 -> 0 with no special case.
- Level:
  - lvl_next = (wr_ptr_next - b_rd_ptr_sync), modulo 2^(ADDR_W+1).
  - wr_level is registered from lvl_next every cycle.
- Full:
  - full <= (wr_ptr_next[ADDR_W] != b_rd_ptr_sync[ADDR_W]) && (wr_ptr_next[ADDR_W-1:0] == b_rd_ptr_sync[ADDR_W-1:0]).
  - Equivalent to lvl_next == 2^ADDR_W.
  - full asserts on the edge of the accept that fills the FIFO, so no cycle exists in which a further write could be accepted.
- Almost full: almost_full <= (lvl_next >= AF_THRESH).
- Read-pointer advance:
  - A change of b_rd_ptr_sync deasserts full and lowers wr_level one wr_clk edge after the change.
  - This is pessimistic, and therefore safe.
- Simultaneous events: an accept and a b_rd_ptr_sync advance in the same cycle are both reflected in lvl_next.
  - Example: level 8, read advances by 1, no write possible (full) -> level 7, full=0.
  - Example: level 7, accept plus read advance by 1 -> level 7, full=0.
- b_rd_ptr_sync is required to be monotonic modulo wrap and never ahead of b_wr_ptr. The block does no checking; the bench asserts wr_level <= 2^ADDR_W.
- No state machine beyond the pointer and flag registers; latency from wr_en to pointer update is 1 cycle.

Optional Feature:
- Macro: FIFO_WR_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit, registered).
  - overflow sets on the edge after any cycle with wr_en=1 and full=1.
  - It is sticky: cleared only by reset.
- Undefined: the overflow port and its register are absent; dropped writes are silent.

Test Plan:
- Reset check: assert reset mid-stream at b_wr_ptr=5 -> all registered outputs return to 0 immediately, without waiting for a clock edge; first accept after release gives b_wr_ptr=1.
- Fill: ADDR_W=3, AF_THRESH=6, b_rd_ptr_sync=0, wr_en held high.
  - Expect 8 strobes at wr_addr 0..7.
  - almost_full rises with the 6th accept (wr_level=6).
  - full rises with the 8th accept; b_wr_ptr=8, wr_level=8.
- Overflow: continue wr_en=1 while full.
  - mem_we=0; b_wr_ptr stays 8.
  - overflow=1 on the next edge with FIFO_WR_OVERFLOW_EN defined, and remains 1 after wr_en drops.
- Drain release: from full, step b_rd_ptr_sync to 3 -> next edge full=0, wr_level=5, almost_full=0.
- Wrap: drive pointers past 15 -> 0 with b_rd_ptr_sync trailing by 8.
  - full asserts at b_wr_ptr=0 with b_rd_ptr_sync=8.
  - wr_level=8 throughout the wrap.
- Simultaneous: wr_level=7, wr_en=1 and b_rd_ptr_sync +1 in the same cycle -> wr_level stays 7, full=0, mem_we=1.
